// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU execute stage with a valid/ready handshake on both sides.
//
// Ports:
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    request present
//   in_ready    request accepted this cycle when in_valid is also high
//   ALUControl  000 add, 001 sub, 010 and, 011 or, 100 srl, 101 slt, 110 pass SrcB, 111 sll
//   SrcA, SrcB  operands, captured at accept
//   out_valid   ALUResult/Zero valid; held until out_ready
//   out_ready   consumer takes the result
//   ALUResult   registered result
//   Zero        registered flag, ALUResult == 0
//
// Build option: define ALU_EXEC_FASTSHIFT_EN to make shifts single-cycle barrel shifts.
// Without it, shifts by N > 0 iterate one bit per cycle in StShift.

module alu_exec_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            ALUControl,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);

    localparam int unsigned ShW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e                  state_q;
    logic                    out_valid_q;
    logic [DATA_WIDTH-1:0]   result_q;
    logic                    zero_q;
    logic [ShW-1:0]          cnt_q;
    logic                    dir_left_q;

    logic [ShW-1:0]          shamt;
    logic [DATA_WIDTH-1:0]   alu_res;
    logic [DATA_WIDTH-1:0]   shift_nxt;
    logic                    go_iter;
    logic                    accept;

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;

    // Result for everything that finishes in one cycle. In the iterative build a shift
    // by zero lands here too and simply passes SrcA.
    always_comb begin
        shamt   = SrcB[ShW-1:0];
        alu_res = '0;
        case (ALUControl)
            3'b000: alu_res = SrcA + SrcB;
            3'b001: alu_res = SrcA - SrcB;
            3'b010: alu_res = SrcA & SrcB;
            3'b011: alu_res = SrcA | SrcB;
`ifdef ALU_EXEC_FASTSHIFT_EN
            3'b100: alu_res = SrcA >> shamt;
            3'b111: alu_res = SrcA << shamt;
`else
            3'b100: alu_res = SrcA;
            3'b111: alu_res = SrcA;
`endif
            3'b101: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            3'b110: alu_res = SrcB;
            default: alu_res = '0;
        endcase
`ifdef ALU_EXEC_FASTSHIFT_EN
        go_iter = 1'b0;
`else
        go_iter = ((ALUControl == 3'b100) || (ALUControl == 3'b111)) && (shamt != '0);
`endif
    end

    assign shift_nxt = dir_left_q ? (result_q << 1) : (result_q >> 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            cnt_q       <= '0;
            dir_left_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        if (go_iter) begin
                            // result_q doubles as the working shift register
                            state_q     <= StShift;
                            out_valid_q <= 1'b0;
                            result_q    <= SrcA;
                            cnt_q       <= shamt;
                            dir_left_q  <= ALUControl[1];
                        end else begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            zero_q      <= (alu_res == '0);
                        end
                    end else if ((state_q == StDone) && out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                StShift: begin
                    result_q <= shift_nxt;
                    zero_q   <= (shift_nxt == '0);
                    cnt_q    <= cnt_q - ShW'(1);
                    if (cnt_q == ShW'(1)) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven bench for alu_exec_unit (DATA_WIDTH = 32).
// Expected latencies follow the iterative build unless ALU_EXEC_FASTSHIFT_EN is defined.

module tb_alu_exec_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   ALUControl;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALUResult;
    logic         Zero;

    int n_vec  = 0;
    int n_fail = 0;

    alu_exec_unit #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALUResult  (ALUResult),
        .Zero       (Zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        int          lat_iter;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from idle, scramble inputs after accept, wait (bounded) for the result.
    task automatic run_op(input vec_t v);
        int lat;
        int busy;
        int exp_lat;
        logic [31:0] held;
        exp_lat = v.lat_iter;
`ifdef ALU_EXEC_FASTSHIFT_EN
        exp_lat = 1;
`endif
        in_valid   = 1'b1;
        ALUControl = v.op;
        SrcA       = v.a;
        SrcB       = v.b;
        out_ready  = 1'b0;
        #1;
        check({v.name, "/in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid   = 1'b0;
        SrcA       = ~v.a;
        SrcB       = v.b ^ 32'h5A5A_5A5A;
        ALUControl = ~v.op;
        lat  = 1;
        busy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            tick();
            lat++;
        end
        check({v.name, "/latency"}, 32'(lat), 32'(exp_lat));
        check({v.name, "/busy"}, 32'(busy), 32'(exp_lat - 1));
        check({v.name, "/result"}, ALUResult, v.res);
        check({v.name, "/zero"}, {31'd0, Zero}, {31'd0, v.zero});
        held = ALUResult;
        tick();
        check({v.name, "/hold"}, {31'd0, out_valid} ^ ALUResult, 32'd1 ^ held);
        out_ready = 1'b1;
        tick();
        check({v.name, "/drain"}, {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int stale;
        vecs.push_back('{"add_ovf",   3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1});
        vecs.push_back('{"add_wrap",  3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1});
        vecs.push_back('{"sub_eq",    3'b001, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1});
        vecs.push_back('{"sub_neg",   3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1});
        vecs.push_back('{"and",       3'b010, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0, 1});
        vecs.push_back('{"or",        3'b011, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0, 1});
        vecs.push_back('{"slt_neg",   3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1});
        vecs.push_back('{"slt_pos",   3'b101, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1});
        vecs.push_back('{"slt_lt",    3'b101, 32'h0000_0005, 32'h0000_0007, 32'h0000_0001, 1'b0, 1});
        vecs.push_back('{"passb",     3'b110, 32'h1111_1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1});
        vecs.push_back('{"sll5",      3'b111, 32'h0000_0001, 32'h0000_0005, 32'h0000_0020, 1'b0, 6});
        vecs.push_back('{"srl31",     3'b100, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 32});
        vecs.push_back('{"srl0",      3'b100, 32'h0000_ABCD, 32'h0000_0000, 32'h0000_ABCD, 1'b0, 1});
        vecs.push_back('{"sll_trunc", 3'b111, 32'hFFFF_FFFF, 32'h0000_0024, 32'hFFFF_FFF0, 1'b0, 5});
        vecs.push_back('{"sll_msb",   3'b111, 32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1'b0, 2});
        vecs.push_back('{"srl_zero",  3'b100, 32'h0000_0010, 32'h0000_0005, 32'h0000_0000, 1'b1, 6});

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        ALUControl = 3'b000; SrcA = '0; SrcB = '0;
        repeat (2) tick();
        check("rst/out_valid", {31'd0, out_valid}, 32'd0);
        check("rst/result", ALUResult, 32'd0);
        check("rst/zero", {31'd0, Zero}, 32'd1);
        rst = 1'b0;
        tick();
        check("rst/in_ready", {31'd0, in_ready}, 32'd1);

        foreach (vecs[i]) run_op(vecs[i]);

        // Stall in DONE, then release with a simultaneous accept, then back-to-back.
        in_valid = 1'b1; ALUControl = 3'b000; SrcA = 32'd5; SrcB = 32'd6; out_ready = 1'b0;
        tick();
        ALUControl = 3'b011; SrcA = 32'hFFFF; SrcB = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check("stall/out_valid", {31'd0, out_valid}, 32'd1);
            check("stall/result", ALUResult, 32'd11);
            check("stall/in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1; ALUControl = 3'b010; SrcA = 32'hF0; SrcB = 32'h3C;
        #1;
        check("release/in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check("b2b1/out_valid", {31'd0, out_valid}, 32'd1);
        check("b2b1/result", ALUResult, 32'h30);
        ALUControl = 3'b001; SrcA = 32'h30; SrcB = 32'h30;
        tick();
        check("b2b2/result", ALUResult, 32'h0);
        check("b2b2/zero", {31'd0, Zero}, 32'd1);
        in_valid = 1'b0;
        tick();
        check("b2b/idle", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Reset during the third cycle of an sll by 10.
        in_valid = 1'b1; ALUControl = 3'b111; SrcA = 32'd1; SrcB = 32'd10;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
`ifndef ALU_EXEC_FASTSHIFT_EN
        check("abort/busy", {31'd0, in_ready}, 32'd0);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort/out_valid", {31'd0, out_valid}, 32'd0);
        check("abort/result", ALUResult, 32'd0);
        check("abort/zero", {31'd0, Zero}, 32'd1);
        check("abort/in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        stale = 0;
        repeat (15) begin
            tick();
            if (out_valid) stale++;
        end
        check("abort/stale", 32'(stale), 32'd0);
        out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: operand and result width; shift amount is SrcB[log2(DATA_WIDTH)-1:0].
REQ-002 The block SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1: operation request present.
REQ-005 The block SHALL have port in_ready, output, 1: block accepts a request this cycle.
REQ-006 The block SHALL have port ALUControl, input, 3: operation code from the ALU decoder.
REQ-007 The block SHALL have ports SrcA and SrcB, input, DATA_WIDTH: operands.
REQ-008 The block SHALL have port out_valid, output, 1: ALUResult/Zero valid.
REQ-009 The block SHALL have port out_ready, input, 1: consumer takes the result.
REQ-010 The block SHALL have port ALUResult, output, DATA_WIDTH: registered result.
REQ-011 The block SHALL have port Zero, output, 1: registered flag, ALUResult == 0.

Function
REQ-012 ALUControl decode SHALL be: 000 add, 001 sub (SrcA-SrcB), 010 and, 011 or, 100 logical right shift, 101 signed set-less-than (result 1 or 0), 110 pass SrcB, 111 left shift.
REQ-013 Add/sub SHALL wrap modulo 2^DATA_WIDTH; no carry/overflow output.
REQ-014 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-015 Accept SHALL occur when in_valid && in_ready; operands and ALUControl captured at accept, later input changes ignored.
REQ-016 in_ready SHALL be 1 in IDLE, 1 in DONE only when out_ready is 1, and 0 in SHIFT.
REQ-017 Non-shift op on accept: result and Zero registered, state -> DONE; out_valid high the next cycle (latency 1).
REQ-018 Shift op on accept with shift amount 0: result = SrcA, state -> DONE (latency 1).
REQ-019 Shift op on accept with shift amount N>0 (iterative build): state -> SHIFT; one bit shifted per cycle with zero fill; after N SHIFT cycles state -> DONE; out_valid at cycle N+1 after accept.
REQ-020 In DONE, out_valid SHALL be 1 and ALUResult/Zero SHALL hold stable until out_ready is 1.
REQ-021 DONE with out_ready=1 and no accept: state -> IDLE, out_valid 0 next cycle.
REQ-022 DONE with out_ready=1 and simultaneous accept: new operation starts that cycle (back-to-back, one result per cycle for non-shift ops).
REQ-023 Codes are fully decoded; no illegal state; FSM encoding unreachable values SHALL return to IDLE.

Reset
REQ-024 On rst=1 at a clock edge: state IDLE, out_valid 0, ALUResult 0, Zero 1, shift counter 0; in_ready 1 the cycle after rst deasserts.
REQ-025 rst in SHIFT or DONE SHALL abort the operation; the pending result is discarded and never presented.

Configuration
REQ-026 Macro ALU_EXEC_FASTSHIFT_EN defined: shifts SHALL complete as single-cycle barrel shifts (latency 1, SHIFT state never entered); undefined: iterative shifting per REQ-019. All other behaviour identical.

Verification
REQ-027 add SrcA=0x7FFFFFFF, SrcB=1 -> 1 cycle later out_valid=1, ALUResult=0x80000000, Zero=0.
REQ-028 sub SrcA=SrcB=0x1234 -> ALUResult=0, Zero=1; slt SrcA=0xFFFFFFFF, SrcB=1 -> ALUResult=1.
REQ-029 sll SrcA=1, SrcB=5 (iterative) -> in_ready=0 for 5 cycles, out_valid at cycle 6, ALUResult=0x20; with ALU_EXEC_FASTSHIFT_EN -> cycle 1.
REQ-030 srl SrcA=0x80000000, SrcB=31 -> ALUResult=1; shift amount 0 -> ALUResult=SrcA at cycle 1.
REQ-031 out_ready held 0 for 4 cycles in DONE -> ALUResult stable, in_ready 0; then out_ready=1 with in_valid=1 (and 0xF0 & 0x3C) -> next cycle ALUResult=0x30.
REQ-032 rst asserted at SHIFT cycle 3 of sll by 10 -> next cycle IDLE, out_valid 0, ALUResult 0, Zero 1; no stale result afterwards.
